// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default memory geometry, reset PC, bubble word,
// and the IF/ID pipeline register layout.
package cpu_pkg;

  localparam int          DEF_IMEM_BYTES = 128;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. It loads a fetched instruction, or inserts a bubble
// that keeps the previous pc/pc4, or holds its contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  output logic [31:0] pc_q,
  output logic [31:0] pc4_q,
  output logic [31:0] instr_q,
  output logic        valid_q
);

  if_id_t stage;

  // Bubble takes precedence over load so that a redirect always squashes the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '{pc: 32'h0, pc4: 32'h0, instr: NOP_WORD, valid: 1'b0};
    end else if (bubble) begin
      stage.instr <= NOP_WORD;
      stage.valid <= 1'b0;
    end else if (load) begin
      stage <= '{pc: pc, pc4: pc4, instr: instr, valid: 1'b1};
    end
  end

  assign pc_q    = stage.pc;
  assign pc4_q   = stage.pc4;
  assign instr_q = stage.instr;
  assign valid_q = stage.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and drives the instruction memory.
// It handles stall, redirect, end-of-memory suspension and a fetch counter.
module if_stage
  import cpu_pkg::*;
#(
  parameter int          IMEM_BYTES = DEF_IMEM_BYTES,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_end,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        load;
  logic        bubble;

  assign pc_plus4   = pc + 32'd4;
  assign target     = {redirect_pc[31:2], 2'b00};
  assign instr_addr = pc;

  assign load   = !redirect && !stall && !fetch_end;
  assign bubble = redirect || (!stall && fetch_end);

  // Priority: reset, redirect, stall, end-of-memory, then sequential fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_end   <= 1'b0;
      fetch_count <= 32'h0;
    end else if (redirect) begin
      pc        <= target;
      fetch_end <= (target > LAST_PC);
    end else if (!stall && !fetch_end) begin
      if (fetch_count != 32'hFFFF_FFFF) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (pc == LAST_PC) begin
        fetch_end <= 1'b1;
      end else begin
        pc <= pc_plus4;
      end
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .bubble  (bubble),
    .pc      (pc),
    .pc4     (pc_plus4),
    .instr   (instr),
    .pc_q    (if_id_pc),
    .pc4_q   (if_id_pc4),
    .instr_q (if_id_instr),
    .valid_q (if_id_valid)
  );

endmodule
